// File: rtl/flick_conditioner_if.sv
// Flick button bundle between the raw pad side and the lamp flasher.
// Latency: none (wires only).
// Backpressure: none; all signals are free-running levels or pulses.
interface flick_conditioner_if;
   logic       flick_raw;
   logic       glitch_clr;
   logic       flick;
   logic       flick_rise;
   logic [7:0] glitch_cnt;

   // Conditioner side: consumes the raw button, produces the clean level.
   modport slave (
      input  flick_raw,
      input  glitch_clr,
      output flick,
      output flick_rise,
      output glitch_cnt
   );

   // Driver/observer side: owns the raw button and the glitch clear.
   modport master (
      output flick_raw,
      output glitch_clr,
      input  flick,
      input  flick_rise,
      input  glitch_cnt
   );
endinterface

// File: rtl/flick_conditioner.sv
// Synchronises and debounces the raw flick button into a clean flick level.
// Latency: flick follows a stable raw level DB_CYC+1 edges after its first sample.
// Backpressure: none; input is sampled every cycle and outputs are never stalled.
module flick_conditioner #(
   parameter int unsigned DB_CYC = 4,
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned FF_DL  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   flick_conditioner_if.slave bus
);

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } state_t;

   // Count value on which the qualifying sample is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [7:0]       GLT_MAX  = 8'hFF;

   // Flops here are zero-delay; FF_DL is kept so the parameter set matches
   // the flasher it plugs into.
   wire unused_ff_dl = (FF_DL != 0);

   logic             s1;
   logic             s2;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             flick_q;
   logic             flick_nxt;
   logic             rise_q;
   logic             rise_nxt;
   logic [7:0]       glitch_q;
   logic [7:0]       glitch_nxt;
   logic             glitch_hit;

   // Two-flop synchroniser for the asynchronous button level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= bus.flick_raw;
         s2 <= s1;
      end
   end

   // State, debounce counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LOW;
         cnt      <= CNT_ZERO;
         flick_q  <= 1'b0;
         rise_q   <= 1'b0;
         glitch_q <= 8'h00;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         flick_q  <= flick_nxt;
         rise_q   <= rise_nxt;
         glitch_q <= glitch_nxt;
      end
   end

   // Debounce decisions: qualify a level change over DB_CYC samples, or
   // fall back to the old level and flag a glitch.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      flick_nxt  = flick_q;
      rise_nxt   = 1'b0;
      glitch_hit = 1'b0;
      case (state)
         LOW: begin
            if (s2) begin
               state_nxt = RISE_CHK;
               cnt_nxt   = CNT_ONE;
            end
         end
         RISE_CHK: begin
            if (s2) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = HIGH;
                  cnt_nxt   = CNT_ZERO;
                  flick_nxt = 1'b1;
                  rise_nxt  = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else begin
               state_nxt  = LOW;
               cnt_nxt    = CNT_ZERO;
               glitch_hit = 1'b1;
            end
         end
         HIGH: begin
            if (!s2) begin
               state_nxt = FALL_CHK;
               cnt_nxt   = CNT_ONE;
            end
         end
         FALL_CHK: begin
            if (!s2) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = LOW;
                  cnt_nxt   = CNT_ZERO;
                  flick_nxt = 1'b0;
               end else begin
                  cnt_nxt = cnt + CNT_ONE;
               end
            end else begin
               state_nxt  = HIGH;
               cnt_nxt    = CNT_ZERO;
               glitch_hit = 1'b1;
            end
         end
         default: begin
            state_nxt = LOW;
            cnt_nxt   = CNT_ZERO;
            flick_nxt = 1'b0;
         end
      endcase
   end

   // Saturating glitch counter; a clear wins over a same-cycle increment.
   always_comb begin
      glitch_nxt = glitch_q;
      if (bus.glitch_clr) begin
         glitch_nxt = 8'h00;
      end else if (glitch_hit && (glitch_q != GLT_MAX)) begin
         glitch_nxt = glitch_q + 8'h01;
      end
   end

   assign bus.flick      = flick_q;
   assign bus.flick_rise = rise_q;
   assign bus.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_flick_conditioner.sv
// Directed bench for the flick conditioner with hand-computed expectations.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: none; stimulus is applied at fixed edge offsets.
module tb_flick_conditioner;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;
   int   rises;
   int   bad;

   flick_conditioner_if bus ();

   flick_conditioner #(
      .DB_CYC(4),
      .CNT_W (4),
      .FF_DL (1)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single comparison point: counts and reports mismatches.
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Two-sample raw pulse; its glitch is counted on the fifth edge.
   task automatic pulse2();
      bus.flick_raw = 1'b1;
      tick();
      tick();
      bus.flick_raw = 1'b0;
      tick();
      tick();
      tick();
   endtask

   initial begin
      n_chk          = 0;
      n_err          = 0;
      rst_n          = 1'b0;
      bus.flick_raw  = 1'b0;
      bus.glitch_clr = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_flick", int'(bus.flick), 0);
      chk("rst_rise", int'(bus.flick_rise), 0);
      chk("rst_glitch", int'(bus.glitch_cnt), 0);
      rst_n = 1'b1;
      tick();
      tick();

      // Clean press: first sample at edge k, flick=1 after edge k+5
      bus.flick_raw = 1'b1;
      rises = 0;
      for (int i = 0; i <= 5; i++) begin
         tick();
         rises += int'(bus.flick_rise);
         if (i == 4) chk("press_flick_k4", int'(bus.flick), 0);
         if (i == 5) begin
            chk("press_flick_k5", int'(bus.flick), 1);
            chk("press_rise_k5", int'(bus.flick_rise), 1);
         end
      end
      tick();
      rises += int'(bus.flick_rise);
      chk("press_rise_k6", int'(bus.flick_rise), 0);
      chk("press_rise_count", rises, 1);
      chk("press_glitch", int'(bus.glitch_cnt), 0);
      tick();
      tick();

      // Release glitch while HIGH: low for 3 samples
      bus.flick_raw = 1'b0;
      tick();
      tick();
      tick();
      bus.flick_raw = 1'b1;
      rises = 0;
      bad   = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         rises += int'(bus.flick_rise);
         if (!bus.flick) bad++;
      end
      chk("relglt_flick_drops", bad, 0);
      chk("relglt_rises", rises, 0);
      chk("relglt_glitch", int'(bus.glitch_cnt), 1);

      // Clean release: same latency as press
      bus.flick_raw = 1'b0;
      for (int i = 0; i <= 5; i++) begin
         tick();
         if (i == 4) chk("rel_flick_k4", int'(bus.flick), 1);
         if (i == 5) chk("rel_flick_k5", int'(bus.flick), 0);
      end
      chk("rel_glitch", int'(bus.glitch_cnt), 1);
      tick();
      tick();

      // Bounce: high 2, low 1, steady high from edge e+3; flick at e+8
      rises = 0;
      bus.flick_raw = 1'b1;
      tick();
      rises += int'(bus.flick_rise);
      tick();
      rises += int'(bus.flick_rise);
      bus.flick_raw = 1'b0;
      tick();
      rises += int'(bus.flick_rise);
      bus.flick_raw = 1'b1;
      for (int i = 3; i <= 9; i++) begin
         tick();
         rises += int'(bus.flick_rise);
         if (i == 7) chk("bounce_flick_e7", int'(bus.flick), 0);
         if (i == 8) chk("bounce_flick_e8", int'(bus.flick), 1);
      end
      chk("bounce_rises", rises, 1);
      chk("bounce_glitch", int'(bus.glitch_cnt), 2);

      // Back to LOW
      bus.flick_raw = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("idle_flick", int'(bus.flick), 0);

      // Saturation: glitch_cnt from 2 with 300 short pulses
      for (int p = 0; p < 5; p++) pulse2();
      chk("sat_after5", int'(bus.glitch_cnt), 7);
      for (int p = 5; p < 300; p++) pulse2();
      chk("sat_255", int'(bus.glitch_cnt), 255);
      chk("sat_flick", int'(bus.flick), 0);

      // Clear coinciding with a further glitch increment
      bus.flick_raw = 1'b1;
      tick();
      tick();
      bus.flick_raw = 1'b0;
      tick();
      tick();
      chk("clr_pre", int'(bus.glitch_cnt), 255);
      bus.glitch_clr = 1'b1;
      tick();
      bus.glitch_clr = 1'b0;
      chk("clr_priority", int'(bus.glitch_cnt), 0);
      pulse2();
      chk("clr_then_count", int'(bus.glitch_cnt), 1);
      bus.glitch_clr = 1'b1;
      tick();
      bus.glitch_clr = 1'b0;
      chk("clr_plain", int'(bus.glitch_cnt), 0);

      // Reset mid-RISE_CHK at cnt=2, raw held high
      bus.flick_raw = 1'b1;
      tick();
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #2;
      chk("midrst_flick", int'(bus.flick), 0);
      chk("midrst_glitch", int'(bus.glitch_cnt), 0);
      rst_n = 1'b1;
      rises = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         rises += int'(bus.flick_rise);
         if (i == 5) chk("midrst_flick_e5", int'(bus.flick), 0);
         if (i == 6) chk("midrst_flick_e6", int'(bus.flick), 1);
      end
      chk("midrst_rises", rises, 1);
      chk("midrst_glitch_after", int'(bus.glitch_cnt), 0);

      // Integration: one full press/release yields exactly one rise,
      // and flick already reads 1 in the rise cycle
      bus.flick_raw = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      rises = 0;
      bad   = 0;
      bus.flick_raw = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         rises += int'(bus.flick_rise);
         if (bus.flick_rise && !bus.flick) bad++;
      end
      bus.flick_raw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         rises += int'(bus.flick_rise);
         if (bus.flick_rise && !bus.flick) bad++;
      end
      chk("integ_rises", rises, 1);
      chk("integ_rise_level", bad, 0);
      chk("integ_final_flick", int'(bus.flick), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
